// File: rtl/pixel_bus_sink.sv
// pixel_bus_sink: receiving end of the shared pixel draw bus.
// Captures one-cycle (x, y, RGB) draw strobes into a small FIFO, reduces the
// colour to BPC bits per channel, and drains each entry as a linear
// framebuffer write. A whole-screen clear can be requested; earlier pixels
// drain first, and pixels arriving during the clear are written after it.
module pixel_bus_sink #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int DEPTH  = 8,
  parameter int BPC    = 3,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              draw_enable,
  input  logic [7:0]        x,
  input  logic [7:0]        y,
  input  logic [23:0]       rgb,
  input  logic              clear_req,
  input  logic [23:0]       clear_color,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [3*BPC-1:0]  fb_data,
  input  logic              fb_ready,
  output logic              full,
  output logic              busy,
  output logic [7:0]        drop_count
);

  localparam int                 PTR_W     = $clog2(DEPTH);
  localparam int                 DATA_W    = 3 * BPC;
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [PTR_W:0]     DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  // Keep the top BPC bits of each channel; truncation, no rounding.
  function automatic logic [DATA_W-1:0] pack_rgb(input logic [23:0] c);
    return {c[23 -: BPC], c[15 -: BPC], c[7 -: BPC]};
  endfunction

  // Low colour bits are intentionally discarded by the packing above.
  logic unused_colour_bits;
  assign unused_colour_bits = ^{rgb, clear_color};

  state_e              state_q;
  logic                clear_pending_q;
  logic [DATA_W-1:0]   clear_color_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic [7:0]          drop_q;

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      count_q,  count_d;

  logic [ADDR_W-1:0]   mem_addr [DEPTH];
  logic [DATA_W-1:0]   mem_data [DEPTH];

  logic                in_bounds;
  logic                fifo_empty;
  logic                fifo_full;
  logic                push;
  logic                pop;
  logic                drop;
  logic                empty_after_pop;
  logic [ADDR_W-1:0]   lin_addr;

  // Full-width address arithmetic, truncated to the framebuffer address width.
  assign lin_addr = ADDR_W'({24'd0, y} * 32'(WIDTH) + {24'd0, x});

  assign in_bounds       = (32'(x) < 32'(WIDTH)) && (32'(y) < 32'(HEIGHT));
  assign fifo_empty      = (count_q == '0);
  assign fifo_full       = (count_q == DEPTH_CNT);
  // A full FIFO drops the strobe even when the head pops on the same edge.
  assign push            = draw_enable && in_bounds && !fifo_full;
  assign drop            = draw_enable && !push;
  assign pop             = (state_q == S_RUN) && !fifo_empty && fb_ready;
  assign empty_after_pop = (count_q == (PTR_W + 1)'(pop));

  // FIFO pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
  end

  // FIFO control state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage write port.
  // NOTE: storage carries no reset; stale entries are never visible because
  // the output decode masks the head whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_q] <= lin_addr;
      mem_data[wr_ptr_q] <= pack_rgb(rgb);
    end
  end

  // Saturating count of discarded strobes (out of bounds or overflow).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_q <= '0;
    end else if (drop && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  // Run/clear sequencer: latches clear requests, waits for the FIFO to drain,
  // then sweeps every framebuffer address with the latched clear colour.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= S_RUN;
      clear_pending_q <= 1'b0;
      clear_color_q   <= '0;
      clr_cnt_q       <= '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (clear_pending_q && empty_after_pop) begin
            state_q         <= S_CLEAR;
            clr_cnt_q       <= '0;
            clear_pending_q <= 1'b0;
          end else if (clear_req && !clear_pending_q) begin
            clear_pending_q <= 1'b1;
            clear_color_q   <= pack_rgb(clear_color);
          end
        end
        S_CLEAR: begin
          if (fb_ready) begin
            if (clr_cnt_q == LAST_ADDR) begin
              state_q   <= S_RUN;
              clr_cnt_q <= '0;
            end else begin
              clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
            end
          end
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  // Output decode from registered state only; stable while fb_ready is low.
  always_comb begin
    fb_we   = 1'b0;
    fb_addr = '0;
    fb_data = '0;
    if (state_q == S_CLEAR) begin
      fb_we   = 1'b1;
      fb_addr = clr_cnt_q;
      fb_data = clear_color_q;
    end else if (!fifo_empty) begin
      fb_we   = 1'b1;
      fb_addr = mem_addr[rd_ptr_q];
      fb_data = mem_data[rd_ptr_q];
    end
  end

  assign full       = fifo_full;
  assign busy       = !fifo_empty || clear_pending_q || (state_q == S_CLEAR);
  assign drop_count = drop_q;

endmodule

// File: tb/tb_pixel_bus_sink.sv
// tb_pixel_bus_sink: directed bench with a write scoreboard. Expected
// framebuffer writes are queued as stimulus is driven and popped by a monitor
// on every accepted write.
module tb_pixel_bus_sink;

  localparam int NPIX = 160 * 120;

  logic        clk;
  logic        resetn;
  logic        draw_enable;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [23:0] rgb;
  logic        clear_req;
  logic [23:0] clear_color;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [8:0]  fb_data;
  logic        fb_ready;
  logic        full;
  logic        busy;
  logic [7:0]  drop_count;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard entry: {address[14:0], data[8:0]}
  logic [23:0] exp_q[$];

  pixel_bus_sink #(
    .WIDTH (160),
    .HEIGHT(120),
    .DEPTH (8),
    .BPC   (3),
    .ADDR_W(15)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .draw_enable(draw_enable),
    .x          (x),
    .y          (y),
    .rgb        (rgb),
    .clear_req  (clear_req),
    .clear_color(clear_color),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_ready   (fb_ready),
    .full       (full),
    .busy       (busy),
    .drop_count (drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference colour reduction: top three bits of R, G, B.
  function automatic logic [8:0] model_pack(input logic [23:0] c);
    return {c[23:21], c[15:13], c[7:5]};
  endfunction

  function automatic logic [14:0] model_addr(input int xx, input int yy);
    return 15'(yy * 160 + xx);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int xx, input int yy, input logic [23:0] c, input bit accept);
    draw_enable = 1'b1;
    x           = 8'(xx);
    y           = 8'(yy);
    rgb         = c;
    if (accept) exp_q.push_back({model_addr(xx, yy), model_pack(c)});
    step();
    draw_enable = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    resetn      = 1'b0;
    draw_enable = 1'b0;
    clear_req   = 1'b0;
    exp_q.delete();
    step();
    step();
    resetn = 1'b1;
  endtask

  // Monitor: every accepted write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (resetn && fb_we && fb_ready) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL sb_unexpected: observed write addr %0d data %0h expected no write", fb_addr, fb_data);
      end
      if (exp_q.size() != 0) begin
        logic [23:0] e;
        e = exp_q.pop_front();
        assert ({fb_addr, fb_data} === e) else begin
          n_err++;
          $error("FAIL sb_write: observed addr %0d data %0h expected addr %0d data %0h",
                 fb_addr, fb_data, e[23:9], e[8:0]);
        end
      end
    end
  end

  initial begin
    bit done;
    resetn      = 1'b1;
    draw_enable = 1'b0;
    x           = '0;
    y           = '0;
    rgb         = '0;
    clear_req   = 1'b0;
    clear_color = '0;
    fb_ready    = 1'b1;

    // Reset state, checked while reset is held.
    #2 resetn = 1'b0;
    #1;
    check("rst_fb_we", fb_we, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_data", fb_data, 0);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_count, 0);
    step();
    step();
    resetn = 1'b1;
    step();

    // Single strobe: one-cycle latency, then idle.
    strobe(5, 2, 24'hFF8040, 1);
    check("single_we", fb_we, 1);
    check("single_addr", fb_addr, 325);
    check("single_data", fb_data, 9'b111_100_010);
    step();
    check("single_we_after", fb_we, 0);
    check("single_busy_after", busy, 0);

    // Out-of-bounds strobes are dropped and never written.
    strobe(160, 0, 24'h112233, 0);
    check("oob_busy0", busy, 0);
    strobe(0, 120, 24'h445566, 0);
    check("oob_busy1", busy, 0);
    strobe(255, 255, 24'h778899, 0);
    check("oob_busy2", busy, 0);
    check("oob_we", fb_we, 0);
    check("oob_drop", drop_count, 3);

    // Overflow under back-pressure, then an in-order drain.
    do_reset();
    fb_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      strobe(i, 0, 24'h10203 * (i + 1), i < 8);
      if (i == 6) check("ovf_not_full7", full, 0);
      if (i == 7) check("ovf_full8", full, 1);
    end
    check("ovf_drop", drop_count, 2);
    check("ovf_hold_we", fb_we, 1);
    check("ovf_hold_addr", fb_addr, 0);
    fb_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("ovf_drain_we", fb_we, 1);
      check("ovf_drain_addr", fb_addr, i);
      step();
    end
    check("ovf_end_we", fb_we, 0);
    check("ovf_end_full", full, 0);
    check("ovf_end_busy", busy, 0);

    // Back-to-back strobes with fb_ready high never fill the FIFO.
    for (int i = 0; i < 20; i++) begin
      strobe((i * 7) % 160, i, 24'hA5C3E1 ^ (24'h010101 * i), 1);
      check("thru_not_full", full, 0);
    end
    step();
    check("thru_busy", busy, 0);
    check("thru_sb_empty", exp_q.size(), 0);

    // Clear ordering: queued pixels first, then the sweep, then late pixels.
    do_reset();
    fb_ready = 1'b0;
    strobe(10, 1, 24'hE0E0E0, 1);
    strobe(20, 3, 24'h204060, 1);
    clear_req   = 1'b1;
    clear_color = 24'h0000FF;
    for (int a = 0; a < NPIX; a++) exp_q.push_back({15'(a), 9'b000_000_111});
    step();
    // A second request while pending is ignored.
    clear_color = 24'hFF0000;
    step();
    clear_req = 1'b0;
    check("clr_busy_pending", busy, 1);
    check("clr_hold_addr", fb_addr, 170);
    fb_ready = 1'b1;
    repeat (100) step();
    check("clr_in_progress_we", fb_we, 1);
    strobe(7, 7, 24'h33CC99, 1);
    done = 1'b0;
    for (int c = 0; c < NPIX + 200; c++) begin
      step();
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    check("clr_finished_in_time", done, 1);
    check("clr_sb_empty", exp_q.size(), 0);
    check("clr_end_we", fb_we, 0);

    // Reset mid-clear with three pixels queued abandons all work.
    do_reset();
    fb_ready    = 1'b1;
    clear_req   = 1'b1;
    clear_color = 24'h123456;
    for (int a = 0; a < NPIX; a++) exp_q.push_back({15'(a), model_pack(24'h123456)});
    step();
    clear_req = 1'b0;
    step();
    strobe(1, 1, 24'hFFFFFF, 1);
    strobe(2, 1, 24'hFFFFFF, 1);
    strobe(3, 1, 24'hFFFFFF, 1);
    repeat (20) step();
    check("midclr_busy", busy, 1);
    #2 resetn = 1'b0;
    exp_q.delete();
    #1;
    check("midclr_rst_we", fb_we, 0);
    check("midclr_rst_addr", fb_addr, 0);
    check("midclr_rst_data", fb_data, 0);
    check("midclr_rst_full", full, 0);
    check("midclr_rst_busy", busy, 0);
    check("midclr_rst_drop", drop_count, 0);
    step();
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("midclr_idle_we", fb_we, 0);
    end

    // Drop counter saturates at 255.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      strobe(200, 5, 24'h0, 0);
      if (i == 253) check("sat_254", drop_count, 254);
      if (i == 254) check("sat_255", drop_count, 255);
    end
    check("sat_300", drop_count, 255);
    check("sat_busy", busy, 0);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_bus_sink.md
# pixel_bus_sink

Receiving end of the shared pixel draw bus driven by the tile and sprite drawers. It captures one-cycle draw strobes carrying (x, y, RGB), buffers them in a small FIFO, and converts each one into a linear framebuffer write. It reduces 24-bit colour to the framebuffer's colour depth. It also provides a whole-screen clear sequence. It sits between the draw bus and the framebuffer write port, absorbing back-pressure when the framebuffer port is not ready.

## Interface
- WIDTH, 160, screen width in pixels
- HEIGHT, 120, screen height in pixels
- DEPTH, 8, FIFO entries (power of two, ≥2)
- BPC, 3, bits per colour channel written to the framebuffer
- ADDR_W, 15, framebuffer address width (must hold WIDTH*HEIGHT-1)
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- draw_enable  in  1  one-cycle draw strobe, sampled every rising edge
- x  in  8  pixel column, valid with draw_enable
- y  in  8  pixel row, valid with draw_enable
- rgb  in  24  {R[7:0], G[7:0], B[7:0]}, valid with draw_enable
- clear_req  in  1  pulse that requests a full-screen clear
- clear_color  in  24  clear colour, captured on the cycle clear_req is accepted
- fb_we  out  1  framebuffer write request
- fb_addr  out  ADDR_W  linear address y*WIDTH + x
- fb_data  out  3*BPC  {R[7:8-BPC], G[7:8-BPC], B[7:8-BPC]}
- fb_ready  in  1  write completes on any edge where fb_we && fb_ready
- full  out  1  FIFO holds DEPTH entries
- busy  out  1  FIFO non-empty, clear pending, or clear in progress
- drop_count  out  8  saturating count of discarded strobes

## Operation
- **Ingress:** on an edge with draw_enable=1:
  - If x≥WIDTH or y≥HEIGHT, the strobe is discarded as out of bounds.
  - Otherwise, if the FIFO count equals DEPTH at that edge, the strobe is discarded as overflow. This holds even if a pop occurs on the same edge.
  - Otherwise, {y*WIDTH+x, packed colour} is pushed.
- **Drop counting:** each discarded strobe increments drop_count by 1. The counter saturates at 255 and never wraps.
- **Address arithmetic:** computed at ingress at full width, then truncated to ADDR_W.
- **Colour packing:** takes the top BPC bits of each channel. There is no rounding.
- **States:**
  - S_RUN (reset state): fb_we = FIFO non-empty; fb_addr and fb_data present the FIFO head. The head is popped on fb_we && fb_ready.
  - S_CLEAR: fb_we=1; fb_addr = clear counter; fb_data = latched clear colour. The counter advances on fb_ready.
- **Clear request:** clear_req=1 in S_RUN sets clear_pending and latches the packed clear_color. clear_req while pending or in S_CLEAR is ignored.
- **S_RUN → S_CLEAR:** taken when clear_pending=1 and the FIFO is empty after the current edge's pop. This drains earlier pixels before the clear. The clear counter is set to 0 and clear_pending is cleared on the transition.
- **Ingress during S_CLEAR:** pushes are still accepted but not drained, so those pixels land after the clear.
- **S_CLEAR → S_RUN:** taken on the edge where counter == WIDTH*HEIGHT-1 and fb_ready=1.
- **Status outputs:** full and busy are derived from registered state.

## Timing
- **Reset:** asserting resetn=0 immediately sets:
  - outputs: fb_we=0, fb_addr=0, fb_data=0, full=0, busy=0, drop_count=0;
  - internal state: FIFO empty, state S_RUN, clear_pending=0, clear counter=0.
- **Reset mid-clear or with a full FIFO:** all pending work is abandoned.
- **Ingress latency:** a strobe accepted at edge N gives fb_we=1 with that pixel's address/data in the cycle after edge N, provided the FIFO was empty and the state is S_RUN.
- **Throughput:** one write per cycle while fb_ready=1. With fb_ready held high, the FIFO never fills under back-to-back strobes.
- **Back-pressure:** while fb_ready=0, fb_we/fb_addr/fb_data hold stable until the write is accepted.
- **Push and pop on the same edge:** count is unchanged. When count=DEPTH, the push is dropped and the pop proceeds, so count becomes DEPTH-1.
- **Clear duration:** with fb_ready held high, a clear lasts exactly WIDTH*HEIGHT cycles in S_CLEAR.
- **Wrap-around:** FIFO pointers wrap modulo DEPTH, and full/empty must stay correct across wraps.

## Test plan
- **Reset mid-clear:** assert resetn=0 during S_CLEAR with the FIFO holding 3 entries → all outputs 0 immediately. After release, fb_we stays 0 until a new strobe.
- **Single strobe:** fb_ready=1; strobe x=5, y=2, rgb=FF8040 → the next cycle shows fb_we=1, fb_addr=325, fb_data=9'b111_100_010, then fb_we=0.
- **Out of bounds:** strobes at (160,0), (0,120), (255,255) → no fb_we, drop_count=3, busy stays 0.
- **Overflow:** fb_ready=0; 10 consecutive strobes at (0..9, 0) → full=1 after 8 strobes, drop_count=2. Release fb_ready → addresses 0..7 are written in order on 8 consecutive cycles, then full=0 and busy=0.
- **Clear ordering:** 2 pixels queued while fb_ready=0, clear_req with clear_color=0000FF, then fb_ready=1 → both pixels are written first, then addresses 0..19199 with fb_data=9'b000_000_111. A strobe during the clear is written after address 19199. busy falls after the final write.
- **Saturation:** 300 out-of-bounds strobes → drop_count=255.
